// File: rtl/pc_fetch_unit.sv
// Program-counter / instruction-fetch stage with req/ready imem handshake and one output slot.
// Optional build macro REDIRECT_COUNT_EN adds the redirect_count output.
module pc_fetch_unit #(
  parameter int unsigned       XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            should_jump,
  input  logic            is_jalr,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jalr_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic            instr_valid,
  output logic            flush,
  output logic            misaligned
`ifdef REDIRECT_COUNT_EN
  ,
  output logic [31:0]     redirect_count
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_wait_addr;
  logic            r_discard;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc_out;
  logic            r_valid;
  logic            r_flush;
  logic            r_misaligned;

  state_t          w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_wait_addr_nxt;
  logic            w_discard_nxt;
  logic [31:0]     w_instr_nxt;
  logic [XLEN-1:0] w_pc_out_nxt;
  logic            w_valid_nxt;
  logic            w_flush_nxt;
  logic            w_misaligned_nxt;

  logic            w_slot_free;
  logic            w_req;
  logic            w_accept;
  logic [XLEN-1:0] w_jalr_aligned;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_inc;

  assign w_slot_free    = !r_valid || !stall;
  // Request is suppressed while reset is held, so it first rises in the cycle after reset.
  assign w_req          = !rst && (((r_state == S_REQ) && w_slot_free) || (r_state == S_WAIT));
  assign w_jalr_aligned = jalr_target & ~XLEN'(1);
  assign w_target       = is_jalr ? w_jalr_aligned : branch_target;
  assign w_pc_inc       = r_pc + XLEN'(4);
  assign w_accept       = w_req && imem_ready && !r_discard && w_slot_free && !should_jump;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_wait_addr_nxt  = r_wait_addr;
    w_discard_nxt    = r_discard;
    w_instr_nxt      = r_instr;
    w_pc_out_nxt     = r_pc_out;
    w_valid_nxt      = r_valid;
    w_flush_nxt      = 1'b0;
    w_misaligned_nxt = r_misaligned;

    if (r_state != S_HALT) begin
      if (should_jump) begin
        w_flush_nxt = 1'b1;
        w_valid_nxt = 1'b0;
        w_instr_nxt = NOP_INSTR;
        if (w_target[1:0] != 2'b00) begin
          w_misaligned_nxt = 1'b1;
          w_discard_nxt    = 1'b0;
          w_state_nxt      = S_HALT;
        end else begin
          w_pc_nxt = w_target;
          // An unanswered request stays outstanding; its response must be dropped.
          if (w_req && !imem_ready) begin
            w_state_nxt   = S_WAIT;
            w_discard_nxt = 1'b1;
            if (r_state == S_REQ) w_wait_addr_nxt = r_pc;
          end else begin
            w_state_nxt   = S_REQ;
            w_discard_nxt = 1'b0;
          end
        end
      end else if (w_accept) begin
        w_instr_nxt  = imem_rdata;
        w_pc_out_nxt = r_pc;
        w_valid_nxt  = 1'b1;
        w_pc_nxt     = w_pc_inc;
        w_state_nxt  = S_REQ;
      end else begin
        if (!stall) begin
          w_valid_nxt = 1'b0;
          w_instr_nxt = NOP_INSTR;
        end
        if ((r_state == S_REQ) && w_req && !imem_ready) begin
          w_state_nxt     = S_WAIT;
          w_wait_addr_nxt = r_pc;
        end else if ((r_state == S_WAIT) && imem_ready && r_discard) begin
          w_discard_nxt = 1'b0;
          w_state_nxt   = S_REQ;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_wait_addr  <= RESET_PC;
      r_discard    <= 1'b0;
      r_instr      <= NOP_INSTR;
      r_pc_out     <= RESET_PC;
      r_valid      <= 1'b0;
      r_flush      <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_wait_addr  <= w_wait_addr_nxt;
      r_discard    <= w_discard_nxt;
      r_instr      <= w_instr_nxt;
      r_pc_out     <= w_pc_out_nxt;
      r_valid      <= w_valid_nxt;
      r_flush      <= w_flush_nxt;
      r_misaligned <= w_misaligned_nxt;
    end
  end

  assign imem_req    = w_req;
  assign imem_addr   = (r_state == S_WAIT) ? r_wait_addr : r_pc;
  assign instr_out   = r_instr;
  assign pc_out      = r_pc_out;
  assign instr_valid = r_valid;
  assign flush       = r_flush;
  assign misaligned  = r_misaligned;

`ifdef REDIRECT_COUNT_EN
  logic [31:0] r_redirect_count;

  always_ff @(posedge clk) begin
    if (rst)          r_redirect_count <= '0;
    else if (r_flush) r_redirect_count <= r_redirect_count + 32'd1;
  end

  assign redirect_count = r_redirect_count;
`endif

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter and instruction-fetch stage that sits directly downstream of the jump-decision logic. It consumes should_jump plus the computed targets, holds the PC, and runs a req/ready handshake with instruction memory. It presents one fetched instruction with its PC to decode. On a redirect it flushes the fetch slot and discards any in-flight response.

Parameters:
XLEN, 32, datapath and PC width
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction presented when the slot is invalid (ADDI x0,x0,0)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  decode cannot accept; hold output slot
should_jump  in  1  redirect request from jump control (valid same cycle)
is_jalr  in  1  select jalr_target instead of branch_target
branch_target  in  XLEN  PC+imm target for branches/JAL
jalr_target  in  XLEN  rs1+imm target for JALR
imem_req  out  1  fetch request
imem_addr  out  XLEN  fetch address, word aligned
imem_ready  in  1  memory response valid this cycle
imem_rdata  in  32  instruction word, valid with imem_ready
instr_out  out  32  instruction to decode
pc_out  out  XLEN  PC of instr_out
instr_valid  out  1  instr_out/pc_out valid
flush  out  1  one-cycle pulse: downstream must squash its stage
misaligned  out  1  sticky: redirect target not word aligned

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, state=S_REQ, discard=0; imem_req=0, instr_valid=0, instr_out=NOP_INSTR, pc_out=RESET_PC, flush=0, misaligned=0. An outstanding request is abandoned. A later imem_ready with no request active is ignored.
- Outputs are registered. imem_req and imem_addr are driven from state and pc, and are asserted from the first cycle after reset.
- States:
  - S_REQ: imem_req=1 when the slot is free (instr_valid=0 or stall=0); otherwise imem_req=0 and hold.
  - S_WAIT: imem_req=1, imem_addr held stable until imem_ready.
  - S_HALT: imem_req=0 forever (left only by rst).
- Transitions:
  - S_REQ, req issued, imem_ready=1 same cycle -> accept, stay S_REQ.
  - S_REQ, req issued, imem_ready=0 -> S_WAIT.
  - S_WAIT, imem_ready=1 -> S_REQ.
- Accept (imem_ready with req active, discard=0, no redirect this cycle):
  - instr_out<=imem_rdata, pc_out<=pc, instr_valid<=1, pc<=pc+4.
  - pc+4 wraps modulo 2^XLEN (0xFFFF_FFFC -> 0x0).
- Consume: stall=0 and no new accept -> instr_valid<=0.
- stall=1: slot held unchanged; no new request leaves S_REQ. S_WAIT still completes and accepts only if the slot is free; otherwise it stays in S_WAIT with req held.
- Redirect (should_jump=1): highest priority, overrides stall and any same-cycle accept.
  - target = is_jalr ? {jalr_target[XLEN-1:1],1'b0} : branch_target.
  - If target[1:0]==0: pc<=target, instr_valid<=0, instr_out<=NOP_INSTR, flush<=1 for exactly one cycle.
    - In S_WAIT without same-cycle ready: discard<=1. The next imem_ready is dropped, discard<=0, go to S_REQ, which fetches target.
    - Same-cycle ready: data dropped, next state S_REQ.
  - If target[1:0]!=0: misaligned<=1 (sticky), pc unchanged, instr_valid<=0, flush<=1, state<=S_HALT. An in-flight response is ignored.
- Back-to-back redirects: each one pulses flush; the last target wins.
- Fetch latency: 1 cycle from req to valid when memory answers combinationally; N+1 when ready arrives N cycles late.

Optional Feature:
- Macro REDIRECT_COUNT_EN.
- Defined: adds output redirect_count (32 bits), reset to 0. Increments by 1 on every cycle flush is asserted, including misaligned redirects. Wraps 0xFFFF_FFFF -> 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, single-cycle-ready memory, stall=0 -> pc_out sequence 0x0,0x4,0x8 on consecutive cycles, instr_valid=1 from cycle 2.
- Memory ready delayed 3 cycles -> imem_addr stays 0x4 for 3 cycles, instr_valid low meanwhile, then pc_out=0x4.
- should_jump=1, is_jalr=0, branch_target=0x100 while in S_WAIT for 0x8 -> flush one cycle; returning 0x8 data dropped; next valid pc_out=0x100.
- is_jalr=1, jalr_target=0x203 -> target 0x202, misaligned=1, flush=1, imem_req stays 0 until rst; with REDIRECT_COUNT_EN, redirect_count=1.
- stall=1 for 4 cycles with instr_valid=1 at pc_out=0x10 -> instr_out/pc_out unchanged, no new request; stall=0 -> next pc_out=0x14.
- RESET_PC=0xFFFF_FFFC -> pc_out 0xFFFF_FFFC then 0x0; assert rst mid-S_WAIT -> outputs return to reset values next cycle.
